// File: rtl/multdiv_unit.sv
// Iterative signed multiplier (radix-2 Booth) / divider (restoring) for the execute stage.
// Every operation takes WIDTH+1 cycles from the start edge to the one-cycle ready strobe.
//
// state | meaning
// IDLE  | waiting for a ctrl_MULT / ctrl_DIV pulse
// RUN   | one Booth or restoring-division step per cycle, WIDTH steps
// DONE  | registers result/exception and pulses ready; may accept the next start
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             op_mul;

    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH:0] prod;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             div_err;

    logic             start;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             a_is_min;
    logic             b_is_neg1;

    logic [WIDTH:0]   booth_hi;
    logic [WIDTH:0]   booth_m;
    logic [WIDTH:0]   booth_sum;
    logic [2*WIDTH:0] prod_next;

    logic [WIDTH:0]   div_shift;
    logic             div_ge;

    logic             mul_ovf;

    always_comb begin
        start     = ctrl_MULT | ctrl_DIV;
        abs_a     = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        abs_b     = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
        a_is_min  = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}});
        b_is_neg1 = (data_operandB == {WIDTH{1'b1}});
    end

    // Booth add/sub is done one bit wider so negating the most negative
    // multiplicand keeps its true sign for the arithmetic shift.
    always_comb begin
        booth_hi = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
        booth_m  = {mcand[WIDTH-1], mcand};
        case (prod[1:0])
            2'b01:   booth_sum = booth_hi + booth_m;
            2'b10:   booth_sum = booth_hi - booth_m;
            default: booth_sum = booth_hi;
        endcase
        prod_next = {booth_sum, prod[WIDTH:1]};
    end

    always_comb begin
        div_shift = {rem, quo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, dvsr});
    end

    // Overflow when product bits [2W-1:W-1] are not a pure sign extension.
    always_comb begin
        mul_ovf = !((&prod[2*WIDTH:WIDTH]) || (~|prod[2*WIDTH:WIDTH]));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            op_mul         <= 1'b0;
            mcand          <= '0;
            prod           <= '0;
            rem            <= '0;
            quo            <= '0;
            dvsr           <= '0;
            neg_q          <= 1'b0;
            div_err        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;

            case (state)
                RUN: begin
                    prod <= prod_next;
                    rem  <= div_ge ? WIDTH'(div_shift - {1'b0, dvsr}) : div_shift[WIDTH-1:0];
                    quo  <= {quo[WIDTH-2:0], div_ge};
                    if (cnt != CW'(WIDTH)) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (op_mul) begin
                        data_result    <= prod[WIDTH:1];
                        data_exception <= mul_ovf;
                    end else if (div_err) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= neg_q ? (~quo + 1'b1) : quo;
                        data_exception <= 1'b0;
                    end
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: ;
            endcase

            // A start in DONE overrides the return to IDLE: back-to-back issue.
            if (state != RUN && start) begin
                op_mul  <= ctrl_MULT;
                mcand   <= data_operandA;
                prod    <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                rem     <= '0;
                quo     <= abs_a;
                dvsr    <= abs_b;
                neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_err <= (data_operandB == '0) || (a_is_min && b_is_neg1);
                cnt     <= '0;
                busy    <= 1'b1;
                state   <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized and directed checks of multdiv_unit against a plain-arithmetic model,
// including fixed latency, ignored pulses, back-to-back issue and async reset abort.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    bit          nxt_go = 1'b0;
    bit          nxt_mul = 1'b0;
    logic [31:0] nxt_a = '0;
    logic [31:0] nxt_b = '0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     sa;
        int     sb;
        sa = $signed(a);
        sb = $signed(b);
        if (mul) begin
            p = longint'(sa) * longint'(sb);
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (sb == 0 || (sa == 32'sh80000000 && sb == -1)) begin
            r = '0;
            e = 1'b1;
        end else begin
            r = sa / sb;
            e = 1'b0;
        end
    endfunction

    task automatic quiet(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("quiet", bad, 0);
    endtask

    // pulse_at: cycle after start at which a stray ctrl_DIV is pulsed (0 = none).
    // chained: the start edge was already driven by the previous call's DONE edge.
    task automatic do_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, input bit both, input bit chained);
        logic [31:0] er;
        logic        ee;
        bit          go_next;
        int          bad;
        model(mul, a, b, er, ee);
        if (!chained) begin
            @(negedge clock);
            data_operandA = a;
            data_operandB = b;
            ctrl_MULT     = mul;
            ctrl_DIV      = !mul || both;
            @(posedge clock);
            #1;
        end
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        check("busy_start", busy, 1);
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            if (i == pulse_at) ctrl_DIV = 1'b1;
            @(posedge clock);
            #1;
            ctrl_DIV = 1'b0;
            if (data_resultRDY !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("run_window", bad, 0);
        go_next = nxt_go;
        if (go_next) begin
            data_operandA = nxt_a;
            data_operandB = nxt_b;
            ctrl_MULT     = nxt_mul;
            ctrl_DIV      = !nxt_mul;
            nxt_go        = 1'b0;
        end
        @(posedge clock);
        #1;
        check("rdy_at_33", data_resultRDY, 1);
        check(mul ? "mul_result" : "div_result", data_result, er);
        check(mul ? "mul_exc" : "div_exc", data_exception, ee);
        check("busy_end", busy, go_next);
        if (!go_next) begin
            @(posedge clock);
            #1;
            check("rdy_one_cycle", data_resultRDY, 0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rm;

        #2 reset = 1'b1;
        #1;
        check("rst_result", data_result, 0);
        check("rst_exc", data_exception, 0);
        check("rst_rdy", data_resultRDY, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        do_op(1'b1, 32'd7, 32'hFFFFFFFD, 0, 1'b0, 1'b0);
        do_op(1'b1, 32'h7FFFFFFF, 32'd2, 0, 1'b0, 1'b0);
        do_op(1'b1, 32'h80000000, 32'd1, 0, 1'b0, 1'b0);
        do_op(1'b0, 32'hFFFFFFF9, 32'd2, 0, 1'b0, 1'b0);
        do_op(1'b0, 32'd100, 32'hFFFFFFF9, 0, 1'b0, 1'b0);
        do_op(1'b0, 32'd5, 32'd0, 0, 1'b0, 1'b0);
        do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 1'b0);
        do_op(1'b1, 32'h80000000, 32'h80000000, 0, 1'b0, 1'b0);

        // stray div at cycle 10 and both ctrls on the start edge
        do_op(1'b1, 32'd12345, 32'hFFFFE57B, 10, 1'b1, 1'b0);
        quiet(3);
        // pulse one edge before busy falls must not start anything
        do_op(1'b1, 32'd3, 32'd4, 32, 1'b0, 1'b0);
        quiet(5);

        nxt_go  = 1'b1;
        nxt_mul = 1'b0;
        nxt_a   = 32'hFFFFFF9C;
        nxt_b   = 32'd9;
        do_op(1'b1, 32'hFFFFFFFB, 32'hFFFFFFFA, 0, 1'b0, 1'b0);
        do_op(1'b0, 32'hFFFFFF9C, 32'd9, 0, 1'b0, 1'b1);

        // async reset 15 cycles into a divide; previous result is nonzero
        do_op(1'b1, 32'd7, 32'hFFFFFFFD, 0, 1'b0, 1'b0);
        @(negedge clock);
        data_operandA = 32'd1000;
        data_operandB = 32'd7;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (14) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("abort_result", data_result, 0);
        check("abort_exc", data_exception, 0);
        check("abort_rdy", data_resultRDY, 0);
        check("abort_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        quiet(40);
        do_op(1'b1, 32'hFFFFFF00, 32'd300, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rm = 1'($urandom_range(0, 1));
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 65535)) - 32'd32768;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = 32'($urandom_range(0, 65535)) - 32'd32768;
                default: rb = $urandom;
            endcase
            do_op(rm, ra, rb, 0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
